ld_cell_a2d: RTL and testbench

SPI master that drives the load-cell and battery A2D converter and produces the `lft_ld`, `rght_ld` and `batt` readings consumed by the rider-detect and steering-enable logic. On each `nxt` request it runs one round-robin round of three channel conversions. Each conversion takes two 16-bit SPI transactions: the first sends the channel address, the second returns that channel's result. When the round completes, all three registers are updated and `vld` pulses for one cycle.

---
 rtl/ld_cell_a2d.sv | 165 ++++++++++++++++
 tb/tb_ld_cell_a2d.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ld_cell_a2d.sv
// SPI master that runs LFT/RGHT/BATT conversion rounds on the load-cell A2D.
// Build option LD_AVG_EN: first-order averaging of lft_ld and rght_ld.
module ld_cell_a2d #(
   parameter logic [2:0] LFT_CH  = 3'd0,
   parameter logic [2:0] RGHT_CH = 3'd4,
   parameter logic [2:0] BATT_CH = 3'd5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        nxt,
   input  logic        MISO,
   output logic        SS_n,
   output logic        SCLK,
   output logic        MOSI,
   output logic [11:0] lft_ld,
   output logic [11:0] rght_ld,
   output logic [11:0] batt,
   output logic        busy,
   output logic        vld
);

   typedef enum logic [2:0] {IDLE, FRONT, SHIFT, BACK, GAP, DONE} state_t;

   state_t      state;
   logic [4:0]  div;
   logic [3:0]  bit_cnt;
   logic [2:0]  idx;
   logic [4:0]  cnt;
   logic [15:0] tx_sr;
   logic [11:0] rx_sr;
   logic [1:0]  nxt_pair;
   logic [15:0] nxt_cmd;
   logic [11:0] lft_new;
   logic [11:0] rght_new;

   function automatic logic [15:0] cmd(input logic [1:0] pair);
      logic [2:0] ch;
      case (pair)
         2'd0:    ch = LFT_CH;
         2'd1:    ch = RGHT_CH;
         default: ch = BATT_CH;
      endcase
      return {2'b00, ch, 11'h000};
   endfunction

   // A and B of one channel share the address; the next channel starts after each B.
   assign nxt_pair = idx[2:1] + {1'b0, idx[0]};
   assign nxt_cmd  = cmd(nxt_pair);

`ifdef LD_AVG_EN
   logic primed;

   always_ff @(posedge clk) begin
      if (rst)
         primed <= 1'b0;
      else if (state == GAP && idx == 3'd5)
         primed <= 1'b1;
   end

   assign lft_new  = primed ? 12'(({1'b0, lft_ld}  + {1'b0, rx_sr}) >> 1) : rx_sr;
   assign rght_new = primed ? 12'(({1'b0, rght_ld} + {1'b0, rx_sr}) >> 1) : rx_sr;
`else
   assign lft_new  = rx_sr;
   assign rght_new = rx_sr;
`endif

   // NOTE: every register here is sequential state, so all updates are non-blocking
   // and the whole FSM plus its registered outputs lives in one clocked block.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         SS_n    <= 1'b1;
         SCLK    <= 1'b1;
         MOSI    <= 1'b0;
         busy    <= 1'b0;
         vld     <= 1'b0;
         lft_ld  <= '0;
         rght_ld <= '0;
         batt    <= '0;
         div     <= '0;
         bit_cnt <= '0;
         idx     <= '0;
         cnt     <= '0;
         tx_sr   <= '0;
         rx_sr   <= '0;
      end else begin
         vld <= 1'b0;
         case (state)
            IDLE: begin
               if (nxt) begin
                  state <= FRONT;
                  busy  <= 1'b1;
                  SS_n  <= 1'b0;
                  cnt   <= '0;
                  MOSI  <= nxt_cmd[15];
                  tx_sr <= {nxt_cmd[14:0], 1'b0};
               end
            end
            FRONT: begin
               cnt <= cnt + 5'd1;
               if (cnt == 5'd7) begin
                  state   <= SHIFT;
                  SCLK    <= 1'b0;
                  div     <= '0;
                  bit_cnt <= '0;
               end
            end
            SHIFT: begin
               div <= div + 5'd1;
               if (div == 5'd15) begin
                  SCLK    <= 1'b1;
                  rx_sr   <= {rx_sr[10:0], MISO};
                  bit_cnt <= bit_cnt + 4'd1;
                  if (bit_cnt == 4'd15) begin
                     state <= BACK;
                     cnt   <= '0;
                  end
               end else if (div == 5'd31) begin
                  // The porch fall entering SHIFT does not advance, so bit 15 meets the first rise.
                  SCLK  <= 1'b0;
                  MOSI  <= tx_sr[15];
                  tx_sr <= {tx_sr[14:0], 1'b0};
               end
            end
            BACK: begin
               cnt <= cnt + 5'd1;
               if (cnt == 5'd15) begin
                  state <= GAP;
                  SS_n  <= 1'b1;
                  MOSI  <= 1'b0;
                  cnt   <= '0;
               end
            end
            GAP: begin
               cnt <= cnt + 5'd1;
               if (cnt == 5'd0 && idx[0]) begin
                  case (idx[2:1])
                     2'd0:    lft_ld  <= lft_new;
                     2'd1:    rght_ld <= rght_new;
                     default: batt    <= rx_sr;
                  endcase
               end
               if (idx == 3'd5) begin
                  state <= DONE;
                  vld   <= 1'b1;
               end else if (cnt == 5'd31) begin
                  state <= FRONT;
                  SS_n  <= 1'b0;
                  cnt   <= '0;
                  idx   <= idx + 3'd1;
                  MOSI  <= nxt_cmd[15];
                  tx_sr <= {nxt_cmd[14:0], 1'b0};
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
               idx   <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ld_cell_a2d.sv
// Randomized bench for ld_cell_a2d with an A2D slave model and a round-level reference.
`timescale 1ns/1ps
module tb_ld_cell_a2d;

   localparam logic [2:0] LFT_CH  = 3'd0;
   localparam logic [2:0] RGHT_CH = 3'd4;
   localparam logic [2:0] BATT_CH = 3'd5;

   logic        clk = 1'b0;
   logic        rst;
   logic        nxt;
   logic        MISO = 1'b0;
   logic        SS_n, SCLK, MOSI, busy, vld;
   logic [11:0] lft_ld, rght_ld, batt;

   int n_checks = 0;
   int n_fail   = 0;

   logic [11:0] a2d_val [8];
   logic [11:0] cur_l, cur_r, cur_b, new_l, new_r, new_b;
   bit          primed;
   int          vld_cnt = 0;
   int          sclk_idle_err = 0;

   // slave-model / window-monitor state
   logic        prev_ss = 1'b1, prev_sclk = 1'b1, in_tx = 1'b0;
   int          ss_len, rises, win_idx = 0, pend = -1, slot;
   logic [15:0] mosi_word, resp;
   logic [2:0]  a_ch = 3'd0;

   ld_cell_a2d #(.LFT_CH(LFT_CH), .RGHT_CH(RGHT_CH), .BATT_CH(BATT_CH)) dut (
      .clk(clk), .rst(rst), .nxt(nxt), .MISO(MISO),
      .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
      .lft_ld(lft_ld), .rght_ld(rght_ld), .batt(batt),
      .busy(busy), .vld(vld)
   );

   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] exp_word(input int w);
      logic [2:0] ch;
      case (w / 2)
         0:       ch = LFT_CH;
         1:       ch = RGHT_CH;
         default: ch = BATT_CH;
      endcase
      return {2'b00, ch, 11'h000};
   endfunction

   function automatic logic [11:0] upd(input logic [11:0] old_v, input logic [11:0] s, input bit avg);
      int sum;
      if (!avg) return s;
      sum = int'(old_v) + int'(s);
      return 12'(sum / 2);
   endfunction

   // A2D slave: answers B with the value of the channel addressed in the preceding A.
   always @(negedge clk) begin
      if (rst === 1'b1) begin
         in_tx = 1'b0; win_idx = 0; pend = -1;
         prev_ss = 1'b1; prev_sclk = 1'b1; MISO = 1'b0;
      end else begin
         if (pend >= 0) begin
            case (pend)
               0:       check("lft_update", lft_ld, new_l);
               1:       check("rght_update", rght_ld, new_r);
               default: check("batt_update", batt, new_b);
            endcase
            pend = -1;
         end
         if (SS_n === 1'b1 && SCLK !== 1'b1) sclk_idle_err++;
         if (prev_ss && SS_n === 1'b0) begin
            in_tx = 1'b1; ss_len = 0; rises = 0; mosi_word = '0;
            resp = win_idx[0] ? {4'($urandom), a2d_val[a_ch]} : 16'($urandom);
         end
         if (SS_n === 1'b0) begin
            ss_len++;
            if (!prev_sclk && SCLK === 1'b1) begin
               mosi_word = {mosi_word[14:0], MOSI};
               rises++;
            end
            if (rises < 16) MISO = resp[15 - rises];
         end
         if (in_tx && SS_n === 1'b1) begin
            in_tx = 1'b0;
            check("ss_low_len", ss_len, 520);
            check("sclk_rises", rises, 16);
            check("mosi_word", mosi_word, exp_word(win_idx));
            if (!win_idx[0]) begin
               a_ch = mosi_word[13:11];
            end else begin
               slot = win_idx / 2;
               case (slot)
                  0:       check("lft_hold", lft_ld, cur_l);
                  1:       check("rght_hold", rght_ld, cur_r);
                  default: check("batt_hold", batt, cur_b);
               endcase
               pend = slot;
            end
            win_idx++;
         end
         if (vld === 1'b1) begin
            vld_cnt++;
            win_idx = 0;
         end
         prev_ss = SS_n;
         prev_sclk = SCLK;
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ss_n"}, SS_n, 1);
      check({tag, "_sclk"}, SCLK, 1);
      check({tag, "_mosi"}, MOSI, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_vld"}, vld, 0);
      check({tag, "_lft"}, lft_ld, 0);
      check({tag, "_rght"}, rght_ld, 0);
      check({tag, "_batt"}, batt, 0);
   endtask

   // One round from nxt to vld; spam_at pulses a stray nxt, rst_at aborts with reset.
   task automatic run_round(input int spam_at, input int rst_at);
      int n;
      int vc0;
      bit avg;
`ifdef LD_AVG_EN
      avg = primed;
`else
      avg = 1'b0;
`endif
      new_l = upd(cur_l, a2d_val[LFT_CH], avg);
      new_r = upd(cur_r, a2d_val[RGHT_CH], avg);
      new_b = a2d_val[BATT_CH];
      vc0 = vld_cnt;
      @(posedge clk); #1; nxt = 1'b1;
      @(posedge clk); #1; nxt = 1'b0;
      check("busy_rise", busy, 1);
      check("ss_fall", SS_n, 0);
      check("sclk_front", SCLK, 1);
      n = 1;
      while (vld !== 1'b1 && n < 4000) begin
         nxt = (n == spam_at);
         if (n == rst_at) begin
            rst = 1'b1;
            @(posedge clk); #1;
            check_reset_outputs("mid_rst");
            rst = 1'b0;
            cur_l = '0; cur_r = '0; cur_b = '0; primed = 1'b0;
            return;
         end
         @(posedge clk); #1;
         n++;
      end
      nxt = 1'b0;
      check("round_len", n, 3282);
      check("vld_busy", busy, 1);
      check("lft_ld", lft_ld, new_l);
      check("rght_ld", rght_ld, new_r);
      check("batt", batt, new_b);
      @(posedge clk); #1;
      check("vld_one_cycle", vld, 0);
      check("busy_end", busy, 0);
      cur_l = new_l; cur_r = new_r; cur_b = new_b; primed = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      check("single_vld", vld_cnt, vc0 + 1);
      check("stays_idle", busy, 0);
   endtask

   task automatic randomize_a2d();
      for (int c = 0; c < 8; c++) a2d_val[c] = 12'($urandom);
   endtask

   initial begin
      int idle_bad;
      rst = 1'b1; nxt = 1'b0; primed = 1'b0;
      cur_l = '0; cur_r = '0; cur_b = '0;
      for (int c = 0; c < 8; c++) a2d_val[c] = '0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b0;

      idle_bad = 0;
      repeat (100) begin
         @(posedge clk); #1;
         if (SS_n !== 1'b1 || SCLK !== 1'b1 || busy !== 1'b0 || vld !== 1'b0) idle_bad++;
      end
      check("idle_quiet", idle_bad, 0);
      check("idle_lft", lft_ld, 0);

      a2d_val[LFT_CH]  = 12'hA5C;
      a2d_val[RGHT_CH] = 12'h3F1;
      a2d_val[BATT_CH] = 12'hC00;
      run_round(-1, -1);
      check("r1_lft_a5c", lft_ld, 12'hA5C);
      check("r1_rght_3f1", rght_ld, 12'h3F1);
      check("r1_batt_c00", batt, 12'hC00);

      randomize_a2d();
      run_round(1000, -1);

      randomize_a2d();
      run_round(-1, 1500);
      randomize_a2d();
      run_round(-1, -1);

      for (int r = 0; r < 4; r++) begin
         randomize_a2d();
         run_round(($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 3200)) : -1, -1);
         repeat ($urandom_range(0, 20)) @(posedge clk);
      end

      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      cur_l = '0; cur_r = '0; cur_b = '0; primed = 1'b0;
      randomize_a2d();
      a2d_val[LFT_CH] = 12'h400;
      run_round(-1, -1);
      check("avg_r1_lft", lft_ld, 12'h400);
      randomize_a2d();
      a2d_val[LFT_CH] = 12'h800;
      run_round(-1, -1);
`ifdef LD_AVG_EN
      check("avg_r2_lft", lft_ld, 12'h600);
`else
      check("avg_r2_lft", lft_ld, 12'h800);
`endif

      check("sclk_idle_high", sclk_idle_err, 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
